// File: rtl/gray_counter.sv
// Handshaked up/down Gray-code counter with clear, load and one-cycle wrap pulse.
// Define GRAY_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module gray_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] gray,
    output logic         gray_valid,
    input  logic         gray_ready,
    output logic         wrap
);

    typedef enum logic {IDLE, OFFER} state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    logic [N-1:0] bcnt;
    logic [N-1:0] bnext;
    logic         stall;

    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic at_limit(input logic [N-1:0] b, input logic dir);
        return dir ? (b == {N{1'b1}}) : (b == {N{1'b0}});
    endfunction

    // Limit handling lives here so the FSM is identical in both builds.
    function automatic logic [N-1:0] step(input logic [N-1:0] b, input logic dir);
`ifdef GRAY_COUNTER_SATURATE_EN
        if (at_limit(b, dir))
            return b;
`endif
        return dir ? (b + ONE) : (b - ONE);
    endfunction

    assign stall = (state == OFFER) && !gray_ready;
    assign bnext = step(bcnt, up);

    // gray is registered alongside bcnt so no input reaches it combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bcnt       <= '0;
            gray       <= '0;
            gray_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                bcnt       <= '0;
                gray       <= '0;
                gray_valid <= 1'b0;
            end else if (load && !stall) begin
                bcnt <= load_val;
                gray <= bin2gray(load_val);
            end else begin
                case (state)
                    IDLE: begin
                        if (en) begin
                            state      <= OFFER;
                            gray_valid <= 1'b1;
                        end
                    end
                    OFFER: begin
                        if (gray_ready) begin
                            bcnt <= bnext;
                            gray <= bin2gray(bnext);
                            wrap <= at_limit(bcnt, up);
                            if (!en) begin
                                state      <= IDLE;
                                gray_valid <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        gray_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
